// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// A one-entry holding register lets the next byte queue up so frames can run back to back.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 25,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StTxStartBit,
        StTxDataBits,
        StTxParityBit,
        StTxStopBit
    } state_e;

    state_e          r_state, w_state_d;
    logic [CntW-1:0] r_clk_cnt, w_clk_cnt_d;
    logic [2:0]      r_bit_idx, w_bit_idx_d;
    logic            r_stop_idx, w_stop_idx_d;
    logic [7:0]      r_data, w_data_d;
    logic [7:0]      r_hold_byte, w_hold_byte_d;
    logic            r_hold_full, w_hold_full_d;
    logic            r_serial, w_serial_d;
    logic            r_done, w_done_d;
    logic            w_bit_end;

    assign w_bit_end   = (r_clk_cnt == CntLast);
    assign o_TX_Ready  = ~r_hold_full;
    assign o_TX_Active = (r_state != StIdle);
    assign o_TX_Serial = r_serial;
    assign o_TX_Done   = r_done;

    always_comb begin
        w_state_d     = r_state;
        w_clk_cnt_d   = r_clk_cnt;
        w_bit_idx_d   = r_bit_idx;
        w_stop_idx_d  = r_stop_idx;
        w_data_d      = r_data;
        w_hold_byte_d = r_hold_byte;
        w_hold_full_d = r_hold_full;
        w_done_d      = 1'b0;

        if (i_TX_DV && !r_hold_full) begin
            w_hold_full_d = 1'b1;
            w_hold_byte_d = i_TX_Byte;
        end

        case (r_state)
            StIdle: begin
                w_clk_cnt_d = '0;
                if (r_hold_full) begin
                    w_state_d     = StTxStartBit;
                    w_data_d      = r_hold_byte;
                    w_hold_full_d = 1'b0;
                end
            end
            StTxStartBit: begin
                w_clk_cnt_d = w_bit_end ? '0 : r_clk_cnt + CntW'(1);
                if (w_bit_end) begin
                    w_state_d   = StTxDataBits;
                    w_bit_idx_d = 3'd0;
                end
            end
            StTxDataBits: begin
                w_clk_cnt_d = w_bit_end ? '0 : r_clk_cnt + CntW'(1);
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_d    = PARITY_EN ? StTxParityBit : StTxStopBit;
                        w_stop_idx_d = 1'b0;
                    end else begin
                        w_bit_idx_d = r_bit_idx + 3'd1;
                    end
                end
            end
            StTxParityBit: begin
                w_clk_cnt_d = w_bit_end ? '0 : r_clk_cnt + CntW'(1);
                if (w_bit_end) begin
                    w_state_d    = StTxStopBit;
                    w_stop_idx_d = 1'b0;
                end
            end
            StTxStopBit: begin
                w_clk_cnt_d = w_bit_end ? '0 : r_clk_cnt + CntW'(1);
                if (w_bit_end) begin
                    if ((STOP_BITS == 2) && !r_stop_idx) begin
                        w_stop_idx_d = 1'b1;
                    end else begin
                        w_done_d = 1'b1;
                        // A held byte chains straight into the next start bit.
                        if (r_hold_full) begin
                            w_state_d     = StTxStartBit;
                            w_data_d      = r_hold_byte;
                            w_hold_full_d = 1'b0;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                w_state_d   = StIdle;
                w_clk_cnt_d = '0;
            end
        endcase

        case (w_state_d)
            StTxStartBit:  w_serial_d = 1'b0;
            StTxDataBits:  w_serial_d = w_data_d[w_bit_idx_d];
            StTxParityBit: w_serial_d = (^w_data_d) ^ PARITY_ODD;
            default:       w_serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            r_state     <= StIdle;
            r_clk_cnt   <= '0;
            r_bit_idx   <= 3'd0;
            r_stop_idx  <= 1'b0;
            r_data      <= 8'h00;
            r_hold_byte <= 8'h00;
            r_hold_full <= 1'b0;
            r_serial    <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_clk_cnt   <= w_clk_cnt_d;
            r_bit_idx   <= w_bit_idx_d;
            r_stop_idx  <= w_stop_idx_d;
            r_data      <= w_data_d;
            r_hold_byte <= w_hold_byte_d;
            r_hold_full <= w_hold_full_d;
            r_serial    <= w_serial_d;
            r_done      <= w_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (plain, even parity, odd parity, two stop bits) at 4 clocks/bit,
// each watched by a line decoder that pops expected bytes from a per-instance queue.
module tb_uart_tx;
    localparam int Cpb = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dv;
    logic [7:0] tx_byte;
    logic [3:0] ready, active, serial, done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];
    logic [7:0] q3[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_plain (
        .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv[0]), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready[0]), .o_TX_Active(active[0]), .o_TX_Serial(serial[0]),
        .o_TX_Done(done[0]));
    uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) u_even (
        .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv[1]), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready[1]), .o_TX_Active(active[1]), .o_TX_Serial(serial[1]),
        .o_TX_Done(done[1]));
    uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(1)) u_odd (
        .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv[2]), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready[2]), .o_TX_Active(active[2]), .o_TX_Serial(serial[2]),
        .o_TX_Done(done[2]));
    uart_tx #(.CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) u_stop2 (
        .i_Clock(clk), .i_Rst(rst), .i_TX_DV(dv[3]), .i_TX_Byte(tx_byte),
        .o_TX_Ready(ready[3]), .o_TX_Active(active[3]), .o_TX_Serial(serial[3]),
        .o_TX_Done(done[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [7:0] b);
        case (idx)
            0:       q0.push_back(b);
            1:       q1.push_back(b);
            2:       q2.push_back(b);
            default: q3.push_back(b);
        endcase
    endtask

    function automatic int q_size(input int idx);
        case (idx)
            0:       return q0.size();
            1:       return q1.size();
            2:       return q2.size();
            default: return q3.size();
        endcase
    endfunction

    task automatic q_pop(input int idx, output logic [7:0] b);
        case (idx)
            0:       b = q0.pop_front();
            1:       b = q1.pop_front();
            2:       b = q2.pop_front();
            default: b = q3.pop_front();
        endcase
    endtask

    // Decodes the line cycle by cycle and compares it against the next queued byte.
    task automatic monitor(input int idx, input bit pen, input bit podd, input int nstop);
        int         nbits;
        int         k;
        bit         busy;
        bit         done_due;
        logic [11:0] fr;
        logic [7:0] b;
        nbits    = 10 + int'(pen) + nstop - 1;
        busy     = 1'b0;
        done_due = 1'b0;
        k        = 0;
        fr       = '1;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                busy     = 1'b0;
                done_due = 1'b0;
                chk($sformatf("rst_line%0d", idx), serial[idx], 1'b1);
                chk($sformatf("rst_done%0d", idx), done[idx], 1'b0);
                chk($sformatf("rst_active%0d", idx), active[idx], 1'b0);
            end else begin
                chk($sformatf("done_pulse%0d", idx), done[idx], done_due);
                done_due = 1'b0;
                if (!busy && serial[idx] === 1'b0) begin
                    chk($sformatf("frame_expected%0d", idx), q_size(idx) > 0, 1);
                    if (q_size(idx) > 0) q_pop(idx, b);
                    else b = 8'h00;
                    fr    = '1;
                    fr[0] = 1'b0;
                    for (int i = 0; i < 8; i++) fr[i+1] = b[i];
                    if (pen) fr[9] = (^b) ^ podd;
                    busy = 1'b1;
                    k    = 0;
                end
                if (busy) begin
                    chk($sformatf("line_bit%0d_k%0d", idx, k), serial[idx], fr[k / Cpb]);
                    chk($sformatf("active_hi%0d", idx), active[idx], 1'b1);
                    k++;
                    if (k == nbits * Cpb) begin
                        busy     = 1'b0;
                        done_due = 1'b1;
                    end
                end else begin
                    chk($sformatf("active_lo%0d", idx), active[idx], 1'b0);
                end
            end
        end
    endtask

    task automatic wait_done(input int idx, input int c0, input int exp, input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (done[idx] !== 1'b1 && n < 300);
        chk(tag, cyc - c0, exp);
    endtask

    initial begin
        int c0;
        int pulses;
        rst     = 1'b1;
        dv      = '0;
        tx_byte = 8'h00;
        fork
            monitor(0, 1'b0, 1'b0, 1);
            monitor(1, 1'b1, 1'b0, 1);
            monitor(2, 1'b1, 1'b1, 1);
            monitor(3, 1'b0, 1'b0, 2);
        join_none

        // Reset with a strobe present that must be ignored.
        dv[0]   = 1'b1;
        tx_byte = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_ready%0d", i), ready[i], 1'b1);
            chk($sformatf("reset_serial%0d", i), serial[i], 1'b1);
            chk($sformatf("reset_active%0d", i), active[i], 1'b0);
            chk($sformatf("reset_done%0d", i), done[i], 1'b0);
        end
        @(negedge clk);
        rst   = 1'b0;
        dv[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("dv_in_reset_ignored", ready[0], 1'b1);

        // Single byte 0xA5: accept, 1-cycle latency, done after 40 line cycles.
        @(negedge clk);
        dv[0] = 1'b1; tx_byte = 8'hA5; push_exp(0, 8'hA5);
        @(posedge clk); #1; c0 = cyc;
        chk("accept_ready_low", ready[0], 1'b0);
        chk("accept_line_idle", serial[0], 1'b1);
        @(negedge clk);
        dv[0] = 1'b0; tx_byte = 8'h00;
        @(posedge clk); #1;
        chk("start_latency", serial[0], 1'b0);
        chk("ready_after_load", ready[0], 1'b1);
        chk("active_at_start", active[0], 1'b1);
        wait_done(0, c0, 41, "done_single");

        // Even and odd parity on 0xA5: 44-cycle frames.
        @(negedge clk);
        dv[2:1] = 2'b11; tx_byte = 8'hA5; push_exp(1, 8'hA5); push_exp(2, 8'hA5);
        @(posedge clk); #1; c0 = cyc;
        @(negedge clk);
        dv[2:1] = 2'b00; tx_byte = 8'hFF;
        wait_done(1, c0, 45, "done_parity_even");
        chk("done_parity_odd", done[2], 1'b1);

        // Two stop bits on 0x5A.
        @(negedge clk);
        dv[3] = 1'b1; tx_byte = 8'h5A; push_exp(3, 8'h5A);
        @(posedge clk); #1; c0 = cyc;
        @(negedge clk);
        dv[3] = 1'b0; tx_byte = 8'h00;
        wait_done(3, c0, 45, "done_stop2");

        // Back-to-back 0x00 then 0xFF, plus an overrun strobe of 0x3C.
        @(negedge clk);
        dv[0] = 1'b1; tx_byte = 8'h00; push_exp(0, 8'h00);
        @(posedge clk); #1; c0 = cyc;
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("ready_inflight", ready[0], 1'b1);
        dv[0] = 1'b1; tx_byte = 8'hFF; push_exp(0, 8'hFF);
        @(negedge clk);
        chk("ready_held", ready[0], 1'b0);
        tx_byte = 8'h3C;
        @(negedge clk);
        dv[0] = 1'b0;
        wait_done(0, c0, 41, "done_b2b_first");
        chk("b2b_no_gap", serial[0], 1'b0);
        chk("b2b_active", active[0], 1'b1);
        wait_done(0, c0, 81, "done_b2b_second");
        repeat (50) @(posedge clk);
        #1;
        chk("overrun_ready", ready[0], 1'b1);
        chk("overrun_idle", active[0], 1'b0);

        // New byte accepted on the same edge the frame ends.
        @(negedge clk);
        dv[0] = 1'b1; tx_byte = 8'h81; push_exp(0, 8'h81);
        @(posedge clk); #1; c0 = cyc;
        @(negedge clk);
        dv[0] = 1'b0;
        while (cyc < c0 + 40) @(negedge clk);
        dv[0] = 1'b1; tx_byte = 8'h7E; push_exp(0, 8'h7E);
        wait_done(0, c0, 41, "done_edge_first");
        chk("accept_at_done", ready[0], 1'b0);
        chk("idle_gap_line", serial[0], 1'b1);
        @(negedge clk);
        dv[0] = 1'b0;
        @(posedge clk); #1;
        chk("start_after_gap", serial[0], 1'b0);
        wait_done(0, c0, 82, "done_edge_second");

        // Reset during data bit 3 of 0x96.
        @(negedge clk);
        dv[0] = 1'b1; tx_byte = 8'h96; push_exp(0, 8'h96);
        @(posedge clk); #1; c0 = cyc;
        @(negedge clk);
        dv[0] = 1'b0;
        while (cyc < c0 + 18) @(negedge clk);
        chk("in_data_bit3", serial[0], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_serial", serial[0], 1'b1);
        chk("abort_ready", ready[0], 1'b1);
        chk("abort_active", active[0], 1'b0);
        chk("abort_done", done[0], 1'b0);
        @(negedge clk);
        rst    = 1'b0;
        pulses = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) pulses++;
        end
        chk("no_done_after_abort", pulses, 0);

        for (int i = 0; i < 4; i++) chk($sformatf("sb_empty%0d", i), q_size(i), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
